// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and widths for the RC4 pixel memory interface
package rc4_pkg;

    localparam int PIX_W  = 20;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        RC4_IDLE  = 2'b00,
        RC4_READ  = 2'b01,
        RC4_WRITE = 2'b10,
        RC4_RSVD  = 2'b11
    } rc4_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_RWAIT,
        ST_RESP,
        ST_GAP
    } rc4_state_t;

endpackage

// File: rtl/rc4_pixel_mem_if.sv
// rtl/rc4_pixel_mem_if.sv - turns RC4 pixel read/write requests into single SRAM word transactions
module rc4_pixel_mem_if
    import rc4_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] SRC_BASE = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(32'h0010_0000)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [PIX_W-1:0]  img_width_i,
    input  logic [PIX_W-1:0]  img_hight_i,
    input  logic [1:0]        rc4_mode_i,
    input  logic [PIX_W-1:0]  rc4_pix_num_i,
    input  logic [DATA_W-1:0] rc4_wdata_i,
    output logic [DATA_W-1:0] rc4_rdata_o,
    output logic              rc4_dfb_o,
    output logic              rc4_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int LIM_W = 2 * PIX_W;

    rc4_state_t        state;
    rc4_state_t        state_nxt;
    rc4_mode_t         mode_in;
    rc4_mode_t         mode_q;
    logic [PIX_W-1:0]  pix_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LIM_W-1:0]  limit_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              rsvd_dfb_q;
    logic              range_bad;
    logic [PIX_W-1:0]  pix_cnt;

    assign mode_in = rc4_mode_t'(rc4_mode_i);

    // Index is rejected when it lies beyond the image or the image is empty
    always_comb begin
        range_bad = (limit_q == '0) || ({{PIX_W{1'b0}}, pix_q} >= limit_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and bus/handshake outputs
    always_comb begin
        state_nxt   = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        rc4_dfb_o   = rsvd_dfb_q;
        case (state)
            ST_IDLE: begin
                if (mode_in == RC4_READ || mode_in == RC4_WRITE) begin
                    state_nxt = ST_CHECK;
                end else if (mode_in == RC4_RSVD) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_CHECK: state_nxt = range_bad ? ST_RESP : ST_REQ;
            ST_REQ: begin
                mem_req_o = 1'b1;
                mem_we_o  = (mode_q == RC4_WRITE);
                if (mem_gnt_i) begin
                    state_nxt = (mode_q == RC4_WRITE) ? ST_RESP : ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rc4_dfb_o = 1'b1;
                state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latching, limit multiply, address build, read capture, error and write count
    always_ff @(posedge clk) begin
        if (rst_i) begin
            mode_q     <= RC4_IDLE;
            pix_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            limit_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rsvd_dfb_q <= 1'b0;
            pix_cnt    <= '0;
        end else begin
            limit_q    <= LIM_W'(img_width_i) * LIM_W'(img_hight_i);
            rsvd_dfb_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mode_in == RC4_READ || mode_in == RC4_WRITE) begin
                        mode_q  <= mode_in;
                        pix_q   <= rc4_pix_num_i;
                        wdata_q <= rc4_wdata_i;
                    end else if (mode_in == RC4_RSVD) begin
                        err_q      <= 1'b1;
                        rsvd_dfb_q <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (range_bad) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        addr_q <= ((mode_q == RC4_WRITE) ? DST_BASE : SRC_BASE)
                                  + ADDR_W'({pix_q, 2'b00});
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i && mode_q == RC4_WRITE) begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                ST_RWAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rc4_rdata_o = rdata_q;
    assign rc4_err_o   = err_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_rc4_pixel_mem_if.sv
// tb/tb_rc4_pixel_mem_if.sv - randomized self-checking bench for rc4_pixel_mem_if
module tb_rc4_pixel_mem_if;
    import rc4_pkg::*;

    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [19:0] img_width_i, img_hight_i;
    logic [1:0]  rc4_mode_i;
    logic [19:0] rc4_pix_num_i;
    logic [31:0] rc4_wdata_i;
    logic [31:0] rc4_rdata_o;
    logic        rc4_dfb_o, rc4_err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    rc4_pixel_mem_if #(.ADDR_W(32), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
        .clk(clk), .rst_i(rst_i),
        .img_width_i(img_width_i), .img_hight_i(img_hight_i),
        .rc4_mode_i(rc4_mode_i), .rc4_pix_num_i(rc4_pix_num_i), .rc4_wdata_i(rc4_wdata_i),
        .rc4_rdata_o(rc4_rdata_o), .rc4_dfb_o(rc4_dfb_o), .rc4_err_o(rc4_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] src_mem [0:127];
    bit          err_exp;
    int unsigned wr_cnt_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sram_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - SRC;
        if (a >= SRC && off < 32'd512 && a[1:0] == 2'b00) return src_mem[off[8:2]];
        return 32'hBAD0_BAD0;
    endfunction

    // One request from IDLE through GAP, with an SRAM responder that grants after gd
    // request cycles and returns read data rd cycles after the grant.
    task automatic run_txn(input logic [1:0] mode, input logic [19:0] pix, input logic [31:0] wd,
                           input int gd, input int rd, input bit garble);
        longint unsigned limit;
        bit rsvd, is_wr, in_rng;
        int exp_lat, dfb_n, dfb_cyc, req_n, bad_req, gcyc, post;
        logic [31:0] exp_addr, gaddr, rd_seen;
        limit    = longint'(img_width_i) * longint'(img_hight_i);
        rsvd     = (mode == 2'b11);
        is_wr    = (mode == 2'b10);
        in_rng   = !rsvd && limit != 0 && longint'(pix) < limit;
        exp_lat  = rsvd ? 1 : (!in_rng ? 2 : (is_wr ? 3 + gd : 3 + gd + rd));
        exp_addr = (is_wr ? DST : SRC) + 32'(pix) * 32'd4;
        dfb_n = 0; dfb_cyc = -1; req_n = 0; bad_req = 0; gcyc = -1; post = 0;
        gaddr = '0; rd_seen = '0;
        rc4_mode_i = mode; rc4_pix_num_i = pix; rc4_wdata_i = wd;
        for (int c = 1; c <= 60 && post < 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (garble && dfb_n == 0) begin
                rc4_mode_i = 2'($urandom); rc4_pix_num_i = 20'($urandom); rc4_wdata_i = $urandom;
            end
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            if (mem_req_o) begin
                req_n++;
                if (mem_addr_o !== exp_addr || mem_we_o !== is_wr ||
                    (is_wr && mem_wdata_o !== wd) || dfb_n != 0) bad_req++;
                if (req_n == gd + 1) begin
                    mem_gnt_i = 1'b1; gcyc = c; gaddr = mem_addr_o;
                end
            end
            if (!is_wr && gcyc > 0 && c - gcyc == rd) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = sram_read(gaddr);
            end
            if (rc4_dfb_o) begin
                dfb_n++;
                if (dfb_cyc < 0) begin dfb_cyc = c; rd_seen = rc4_rdata_o; end
            end
            if (dfb_n > 0) begin post++; rc4_mode_i = 2'b00; end
        end
        rc4_mode_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        if (!in_rng) err_exp = 1'b1;
        if (in_rng && is_wr) wr_cnt_exp++;
        chk("dfb_count", 64'(dfb_n), 64'd1);
        chk("dfb_latency", 64'(dfb_cyc), 64'(exp_lat));
        chk("req_cycles", 64'(req_n), in_rng ? 64'(gd + 1) : 64'd0);
        chk("req_content", 64'(bad_req), 64'd0);
        if (!is_wr && !rsvd) chk("rdata", 64'(rd_seen), in_rng ? 64'(src_mem[pix[6:0]]) : 64'd0);
        chk("err_sticky", 64'(rc4_err_o), 64'(err_exp));
        chk("pix_cnt", 64'(dut.pix_cnt), 64'(wr_cnt_exp & 32'hF_FFFF));
    endtask

    initial begin
        int lim, quiet;
        for (int i = 0; i < 128; i++) src_mem[i] = $urandom;
        src_mem[5] = 32'hDEAD_BEEF;
        rst_i = 1'b1; img_width_i = 20'd4; img_hight_i = 20'd4;
        rc4_mode_i = 2'b00; rc4_pix_num_i = '0; rc4_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        err_exp = 1'b0; wr_cnt_exp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {60'd0, mem_req_o, mem_we_o, rc4_dfb_o, rc4_err_o}, 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_wdata", 64'(mem_wdata_o), 64'd0);
        chk("rst_rdata", 64'(rc4_rdata_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk); @(negedge clk);

        run_txn(2'b01, 20'd5, 32'h0, 0, 1, 1'b0);
        chk("deadbeef", 64'(rc4_rdata_o), 64'hDEAD_BEEF);
        run_txn(2'b10, 20'd15, 32'h1234_5678, 3, 1, 1'b0);
        run_txn(2'b01, 20'd16, 32'h0, 0, 1, 1'b0);
        run_txn(2'b01, 20'd2, 32'h0, 1, 2, 1'b0);
        run_txn(2'b11, 20'd1, 32'h0, 0, 1, 1'b0);
        quiet = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (mem_req_o || rc4_dfb_o) quiet++;
        end
        chk("idle_quiet", 64'(quiet), 64'd0);
        run_txn(2'b01, 20'd7, 32'h0, 2, 2, 1'b1);
        run_txn(2'b10, 20'd9, $urandom, 1, 1, 1'b1);

        // Reset while waiting for read data; the late rvalid must be ignored
        rc4_mode_i = 2'b01; rc4_pix_num_i = 20'd3;
        @(posedge clk); @(negedge clk); rc4_mode_i = 2'b00;
        @(posedge clk); @(negedge clk);
        chk("rstseq_req", 64'(mem_req_o), 64'd1);
        mem_gnt_i = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt_i = 1'b0; rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        chk("rstseq_ctrl", {60'd0, mem_req_o, mem_we_o, rc4_dfb_o, rc4_err_o}, 64'd0);
        chk("rstseq_rdata", 64'(rc4_rdata_o), 64'd0);
        chk("rstseq_addr", 64'(mem_addr_o), 64'd0);
        err_exp = 1'b0; wr_cnt_exp = 0;
        quiet = 0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            mem_rvalid_i = 1'b0;
            if (rc4_dfb_o || mem_req_o) quiet++;
        end
        chk("rstseq_quiet", 64'(quiet), 64'd0);
        run_txn(2'b01, 20'd6, 32'h0, 0, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] m;
            img_width_i = 20'($urandom_range(0, 8));
            img_hight_i = 20'($urandom_range(1, 8));
            @(posedge clk); @(negedge clk);
            lim = int'(img_width_i) * int'(img_hight_i);
            case ($urandom_range(0, 4))
                0, 1:    m = 2'b01;
                2, 3:    m = 2'b10;
                default: m = 2'b11;
            endcase
            run_txn(m, 20'($urandom_range(0, lim + 3)), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
